// File: rtl/regfile_mbist_ctrl.sv
// -----------------------------------------------------------------------------
// regfile_mbist_ctrl
//
// March C- memory-BIST controller for the 1RW test port of the register-file
// test wrapper. It walks every writable word with the six March C- elements:
//   M0 up (w0), M1 up (r0,w1), M2 up (r1,w0),
//   M3 down (r0,w1), M4 down (r1,w0), M5 up (r0)
// It issues one op per cycle and compares each read one cycle later. It
// reports pass/fail plus the logical address and element of the first
// miscompare.
//
// Logical addresses run 0..N-1 with N = 2^(ADDR_WIDTH-1)-1. The controller
// drives A_T = {1'b0, logical}, so the all-ones lower-bits value is never
// issued. The wrapper maps that value to physical word 0, which is not
// writable.
//
// Optional build macro: MBIST_DIAG_EN
//   defined   : adds fail_cnt_o (16-bit saturating miscompare count). A
//               miscompare does not abort; all 10N ops always run.
//   undefined : the run aborts on the first miscompare.
//
// Ports
//   clk          clock
//   rst_n        synchronous active-low reset
//   start_i      one-cycle start pulse, honoured in IDLE and DONE
//   BIST         test-mode enable to the wrapper (RUN, DRAIN)
//   CSN_T        test chip-select, active low
//   WEN_T        test write-enable, 0 = write, 1 = read
//   A_T          test address
//   D_T          test write data
//   Q_T          test read data, valid the cycle after a read
//   busy_o       test running (RUN, DRAIN)
//   done_o       test finished, held until the next start
//   fail_o       miscompare seen, valid with done_o
//   fail_addr_o  logical address of the first miscompare
//   fail_elem_o  March element (0-5) of the first miscompare
//   fail_cnt_o   (MBIST_DIAG_EN only) number of miscompared reads
// -----------------------------------------------------------------------------
module regfile_mbist_ctrl #(
  parameter int                    ADDR_WIDTH = 5,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] BG_PATTERN = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  output logic                  BIST,
  output logic                  CSN_T,
  output logic                  WEN_T,
  output logic [ADDR_WIDTH-1:0] A_T,
  output logic [DATA_WIDTH-1:0] D_T,
  input  logic [DATA_WIDTH-1:0] Q_T,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  fail_o,
  output logic [ADDR_WIDTH-2:0] fail_addr_o,
  output logic [2:0]            fail_elem_o
`ifdef MBIST_DIAG_EN
  ,
  output logic [15:0]           fail_cnt_o
`endif
);

  localparam int LW = ADDR_WIDTH - 1;
  // Highest logical address N-1 = all ones except the LSB.
  localparam logic [LW-1:0] ADDR_LAST = {{(LW-1){1'b1}}, 1'b0};

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [2:0]    elem_q, elem_d;
  logic [LW-1:0] addr_q, addr_d;
  logic          phase_q, phase_d;     // 0: first op of a pair, 1: second
  logic          rd_vld_q, rd_vld_d;   // read in flight, compare this cycle
  logic          rd_inv_q, rd_inv_d;   // read expects ~BG_PATTERN
  logic [LW-1:0] rd_addr_q, rd_addr_d;
  logic [2:0]    rd_elem_q, rd_elem_d;
  logic          fail_q, fail_d;
  logic [LW-1:0] fail_addr_q, fail_addr_d;
  logic [2:0]    fail_elem_q, fail_elem_d;
  logic [15:0]   cnt_q, cnt_d;

  logic          is_run, two_op, down, is_read, op_inv, miscompare, abort;
  logic [LW-1:0] end_addr;

  // Per-op decode of the current (element, phase) position.
  always_comb begin
    is_run   = (state_q == S_RUN);
    two_op   = (elem_q >= 3'd1) && (elem_q <= 3'd4);
    down     = (elem_q == 3'd3) || (elem_q == 3'd4);
    is_read  = two_op ? !phase_q : (elem_q == 3'd5);
    // Reads of M2/M4 expect "1"; writes of M1/M3 write "1".
    op_inv   = is_read ? (elem_q == 3'd2 || elem_q == 3'd4)
                       : (elem_q == 3'd1 || elem_q == 3'd3);
    end_addr = down ? '0 : ADDR_LAST;
    miscompare = rd_vld_q && (Q_T != (rd_inv_q ? ~BG_PATTERN : BG_PATTERN));
`ifdef MBIST_DIAG_EN
    abort = 1'b0;
`else
    abort = miscompare;
`endif
  end

  always_comb begin
    state_d     = state_q;
    elem_d      = elem_q;
    addr_d      = addr_q;
    phase_d     = phase_q;
    rd_vld_d    = is_run && is_read;
    rd_inv_d    = op_inv;
    rd_addr_d   = addr_q;
    rd_elem_d   = elem_q;
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    fail_elem_d = fail_elem_q;
    cnt_d       = cnt_q;

    if (miscompare && !fail_q) begin
      fail_d      = 1'b1;
      fail_addr_d = rd_addr_q;
      fail_elem_d = rd_elem_q;
    end
    if (miscompare && cnt_q != 16'hFFFF) begin
      cnt_d = cnt_q + 16'd1;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d     = S_RUN;
          elem_d      = '0;
          addr_d      = '0;
          phase_d     = 1'b0;
          fail_d      = 1'b0;
          fail_addr_d = '0;
          fail_elem_d = '0;
          cnt_d       = '0;
        end
      end
      S_RUN: begin
        if (two_op && !phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (addr_q == end_addr) begin
            if (elem_q == 3'd5) begin
              state_d = S_DRAIN;
            end else begin
              elem_d = elem_q + 3'd1;
              // M3 and M4 descend, so they start from the top address.
              addr_d = (elem_q == 3'd2 || elem_q == 3'd3) ? ADDR_LAST : '0;
            end
          end else begin
            addr_d = down ? addr_q - 1'b1 : addr_q + 1'b1;
          end
        end
        // The op of the detect cycle has already been issued; stop here.
        if (abort) begin
          state_d = S_DRAIN;
        end
      end
      default: state_d = S_DONE;  // S_DRAIN: lets the last read be compared
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      elem_q      <= '0;
      addr_q      <= '0;
      phase_q     <= 1'b0;
      rd_vld_q    <= 1'b0;
      rd_inv_q    <= 1'b0;
      rd_addr_q   <= '0;
      rd_elem_q   <= '0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_elem_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      addr_q      <= addr_d;
      phase_q     <= phase_d;
      rd_vld_q    <= rd_vld_d;
      rd_inv_q    <= rd_inv_d;
      rd_addr_q   <= rd_addr_d;
      rd_elem_q   <= rd_elem_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      fail_elem_q <= fail_elem_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    busy_o      = (state_q == S_RUN) || (state_q == S_DRAIN);
    done_o      = (state_q == S_DONE);
    BIST        = busy_o;
    CSN_T       = !is_run;
    WEN_T       = !(is_run && !is_read);
    A_T         = is_run ? {1'b0, addr_q} : '0;
    D_T         = (is_run && !is_read) ? (op_inv ? ~BG_PATTERN : BG_PATTERN) : '0;
    fail_o      = fail_q;
    fail_addr_o = fail_addr_q;
    fail_elem_o = fail_elem_q;
  end

`ifdef MBIST_DIAG_EN
  assign fail_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_regfile_mbist_ctrl.sv
// -----------------------------------------------------------------------------
// tb_regfile_mbist_ctrl
//
// Drives the March C- controller against a behavioural 1RW wrapper model with
// injectable stuck-at bits (applied on read, optionally armed from a given
// cycle). ADDR_WIDTH = 6 gives N = 31 logical words, so a full run is
// 310 ops and done_o rises in cycle 312. Cycle 0 is the cycle in which
// start_i is high; outputs are sampled on the falling edge.
// Also builds with MBIST_DIAG_EN defined.
// -----------------------------------------------------------------------------
module tb_regfile_mbist_ctrl;

  localparam int AW  = 6;
  localparam int DW  = 32;
  localparam int N   = 31;
  localparam int TOT = 10 * N;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_i;
  logic          BIST, CSN_T, WEN_T;
  logic [AW-1:0] A_T;
  logic [DW-1:0] D_T;
  logic [DW-1:0] Q_T = '0;
  logic          busy_o, done_o, fail_o;
  logic [AW-2:0] fail_addr_o;
  logic [2:0]    fail_elem_o;
`ifdef MBIST_DIAG_EN
  logic [15:0]   fail_cnt_o;
`endif

  regfile_mbist_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BG_PATTERN('0)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i),
    .BIST(BIST), .CSN_T(CSN_T), .WEN_T(WEN_T), .A_T(A_T), .D_T(D_T), .Q_T(Q_T),
    .busy_o(busy_o), .done_o(done_o), .fail_o(fail_o),
    .fail_addr_o(fail_addr_o), .fail_elem_o(fail_elem_o)
`ifdef MBIST_DIAG_EN
    , .fail_cnt_o(fail_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  // ---------------- wrapper model ----------------
  logic [DW-1:0] mem [0:63];
  logic [DW-1:0] sa1_arr [0:63];
  logic [DW-1:0] sa0_arr [0:63];
  int            arm_cyc = 0;
  int            cyc_g = 0;

  function automatic logic [DW-1:0] read_model(input logic [AW-1:0] a);
    logic [DW-1:0] v;
    v = mem[a];
    if (cyc_g >= arm_cyc) v = (v | sa1_arr[a]) & ~sa0_arr[a];
    return v;
  endfunction

  always @(posedge clk) begin
    if (!CSN_T) begin
      if (!WEN_T) mem[A_T] <= D_T;
      else        Q_T <= read_model(A_T);
    end
  end

  // ---------------- expected op sequence ----------------
  logic          exp_we [0:TOT-1];
  logic [AW-1:0] exp_a  [0:TOT-1];
  logic [DW-1:0] exp_d  [0:TOT-1];

  task automatic push(inout int idx, input logic we, input int a, input logic one);
    exp_we[idx] = we;
    exp_a[idx]  = AW'(a);
    exp_d[idx]  = (we && one) ? '1 : '0;
    idx++;
  endtask

  task automatic build_expected();
    int idx;
    int a;
    idx = 0;
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < N; i++) begin
        a = (e == 3 || e == 4) ? (N - 1 - i) : i;
        case (e)
          0: push(idx, 1'b1, a, 1'b0);
          1, 3: begin push(idx, 1'b0, a, 1'b0); push(idx, 1'b1, a, 1'b1); end
          2, 4: begin push(idx, 1'b0, a, 1'b0); push(idx, 1'b1, a, 1'b0); end
          default: push(idx, 1'b0, a, 1'b0);
        endcase
      end
    end
  endtask

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_faults();
    for (int i = 0; i < 64; i++) begin
      sa1_arr[i] = '0;
      sa0_arr[i] = '0;
    end
    arm_cyc = 0;
  endtask

  // Starts a run from the current falling edge and follows it until done_o
  // or a cycle budget. pulse_at > 0 re-pulses start_i in that cycle.
  task automatic run(input int pulse_at, output int done_cyc, output int ops,
                     output int last_op, output int bad_addr, output int seq_err,
                     output logic [3:0] c1_flags);
    done_cyc = -1; ops = 0; last_op = 0; bad_addr = 0; seq_err = 0; c1_flags = '0;
    cyc_g   = 0;
    start_i = 1'b1;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      cyc_g = k;
      if (k == 1) c1_flags = {done_o, fail_o, busy_o, BIST};
      if (!CSN_T) begin
        ops++;
        last_op = k;
        if (A_T[AW-1] || A_T[AW-2:0] == '1) bad_addr++;
        if (ops > TOT) seq_err++;
        else if ({WEN_T, A_T, D_T} !== {~exp_we[ops-1], exp_a[ops-1], exp_d[ops-1]})
          seq_err++;
      end
      start_i = (k == pulse_at);
      if (done_o) begin
        done_cyc = k;
        break;
      end
    end
    start_i = 1'b0;
  endtask

  typedef struct {
    int          fa;
    logic [31:0] sa1;
    logic [31:0] sa0;
    int          arm;
    logic        ef;
    int          eaddr;
    int          eelem;
    int          edone;
    int          eops;
    int          ecnt;
  } vec_t;

  vec_t vecs [0:7];

  initial begin
    int done_cyc, ops, last_op, bad_addr, seq_err;
    logic [3:0] c1;
    int edone, eops;

    // fa, sa1, sa0, arm, fail, addr, elem, done, ops, diag count
    vecs[0] = '{7,  32'h1,        32'h0,  0,   1'b1, 7,  1, 49,  47,  3};
    vecs[1] = '{0,  32'h0,        32'h0,  0,   1'b0, 0,  0, 312, 310, 0};
    vecs[2] = '{20, 32'h0,        32'h20, 0,   1'b1, 20, 2, 137, 135, 2};
    vecs[3] = '{0,  32'h80000000, 32'h0,  0,   1'b1, 0,  1, 35,  33,  3};
    vecs[4] = '{30, 32'h0,        32'h1,  0,   1'b1, 30, 2, 157, 155, 2};
    vecs[5] = '{10, 32'h8,        32'h0,  160, 1'b1, 10, 3, 199, 197, 2};
    vecs[6] = '{25, 32'h0,        32'h80, 200, 1'b1, 25, 4, 231, 229, 1};
    vecs[7] = '{30, 32'h4,        32'h0,  270, 1'b1, 30, 5, 312, 310, 1};

    build_expected();
    clear_faults();
    for (int i = 0; i < 64; i++) mem[i] = '0;

    // Reset state
    rst_n = 1'b0; start_i = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_outputs",
        {BIST, CSN_T, WEN_T, A_T, D_T, busy_o, done_o, fail_o, fail_addr_o, fail_elem_o},
        {1'b0, 1'b1, 1'b1, 6'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 3'd0});

    // Table-driven fault runs (back to back, each restarting from DONE)
    for (int v = 0; v < 8; v++) begin
      clear_faults();
      sa1_arr[vecs[v].fa] = vecs[v].sa1;
      sa0_arr[vecs[v].fa] = vecs[v].sa0;
      arm_cyc = vecs[v].arm;
`ifdef MBIST_DIAG_EN
      edone = 312; eops = TOT;
`else
      edone = vecs[v].edone; eops = vecs[v].eops;
`endif
      run(0, done_cyc, ops, last_op, bad_addr, seq_err, c1);
      $display("run vec%0d: done_cyc=%0d ops=%0d fail=%0b addr=%0d elem=%0d",
               v, done_cyc, ops, fail_o, fail_addr_o, fail_elem_o);
      chk("start_clears_status", 64'(c1), 64'(4'b0011));
      chk("done_cycle", 64'(done_cyc), 64'(edone));
      chk("op_count", 64'(ops), 64'(eops));
      chk("last_op_cycle", 64'(last_op), 64'(eops));
      chk("addr_range", 64'(bad_addr), 64'd0);
      chk("op_sequence", 64'(seq_err), 64'd0);
      chk("fail_o", 64'(fail_o), 64'(vecs[v].ef));
      chk("fail_addr_o", 64'(fail_addr_o), 64'(vecs[v].eaddr));
      chk("fail_elem_o", 64'(fail_elem_o), 64'(vecs[v].eelem));
`ifdef MBIST_DIAG_EN
      chk("fail_cnt_o", 64'(fail_cnt_o), 64'(vecs[v].ecnt));
`endif
      @(negedge clk);
      chk("idle_after_done", {61'd0, BIST, CSN_T, done_o}, {61'd0, 1'b0, 1'b1, 1'b1});
    end

    // start_i re-pulsed at cycle 50 of a clean run is ignored
    clear_faults();
    run(50, done_cyc, ops, last_op, bad_addr, seq_err, c1);
    $display("run restart_ignored: done_cyc=%0d ops=%0d fail=%0b", done_cyc, ops, fail_o);
    chk("pulse50_done_cycle", 64'(done_cyc), 64'd312);
    chk("pulse50_op_sequence", 64'(seq_err), 64'd0);
    chk("pulse50_fail", 64'(fail_o), 64'd0);

    // Reset asserted in cycle 100 of a run aborts it
    start_i = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      start_i = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrun_reset_outputs",
        {BIST, CSN_T, WEN_T, A_T, D_T, busy_o, done_o, fail_o, fail_addr_o, fail_elem_o},
        {1'b0, 1'b1, 1'b1, 6'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 3'd0});
    rst_n = 1'b1;
    @(negedge clk);
    chk("after_reset_no_op", 64'(CSN_T), 64'd1);
    run(0, done_cyc, ops, last_op, bad_addr, seq_err, c1);
    $display("run after_reset: done_cyc=%0d ops=%0d fail=%0b", done_cyc, ops, fail_o);
    chk("after_reset_ops", 64'(ops), 64'(TOT));
    chk("after_reset_done_cycle", 64'(done_cyc), 64'd312);
    chk("after_reset_op_sequence", 64'(seq_err), 64'd0);

`ifdef MBIST_DIAG_EN
    // Two stuck-at-0 words: each misses the two "1" reads (M2, M4)
    clear_faults();
    sa0_arr[3]  = 32'h1;
    sa0_arr[20] = 32'h1;
    run(0, done_cyc, ops, last_op, bad_addr, seq_err, c1);
    $display("run diag_two_faults: done_cyc=%0d cnt=%0d addr=%0d", done_cyc, fail_cnt_o, fail_addr_o);
    chk("diag_done_cycle", 64'(done_cyc), 64'd312);
    chk("diag_fail_addr", 64'(fail_addr_o), 64'd3);
    chk("diag_fail_elem", 64'(fail_elem_o), 64'd2);
    chk("diag_fail_cnt", 64'(fail_cnt_o), 64'd4);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
